// File: rtl/iob_cache_be_arbiter_pkg.sv
// Shared definitions for the two-master cache back-end arbiter:
// FSM state encoding and master index constants.
package iob_cache_be_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic MST_0 = 1'b0;
    localparam logic MST_1 = 1'b1;

endpackage

// File: rtl/iob_cache_be_arbiter_if.sv
// IOb native back-end bus bundle. The requester uses the master modport,
// the responder uses the slave modport.
interface iob_cache_be_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  avalid;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic [DATA_W-1:0]     rdata;
    logic                  rvalid;
    logic                  ready;

    modport master (
        output avalid, addr, wdata, wstrb,
        input  rdata, rvalid, ready
    );

    modport slave (
        input  avalid, addr, wdata, wstrb,
        output rdata, rvalid, ready
    );
endinterface

// File: rtl/iob_cache_be_rr_arb.sv
// Stateless 2-input round-robin picker: a lone requester wins, and on a
// tie the master that was not served last wins.
module iob_cache_be_rr_arb
    import iob_cache_be_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant,
    output logic       valid
);

    // Pick a winner from the request vector and the last-served pointer.
    always_comb begin
        grant = MST_0;
        valid = 1'b0;
        case (req)
            2'b01: begin
                grant = MST_0;
                valid = 1'b1;
            end
            2'b10: begin
                grant = MST_1;
                valid = 1'b1;
            end
            2'b11: begin
                grant = ~last;
                valid = 1'b1;
            end
            default: begin
                grant = MST_0;
                valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/iob_cache_be_arbiter.sv
// Two-master to one-slave round-robin arbiter for the cache back-end IOb bus.
// One transaction in flight; read data is routed back to the issuing master.
module iob_cache_be_arbiter
    import iob_cache_be_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NBYTES = DATA_W / 8
) (
    input  logic                   clk_i,
    input  logic                   cke_i,
    input  logic                   arst_i,
    iob_cache_be_arbiter_if.slave  m0,
    iob_cache_be_arbiter_if.slave  m1,
    iob_cache_be_arbiter_if.master mem
);

    state_t              state_r;
    state_t              state_s;
    logic                grant_r;
    logic                grant_s;
    logic                last_r;
    logic                last_s;
    logic                arb_grant_s;
    logic                arb_valid_s;
    logic                sel_avalid_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [DATA_W-1:0]   sel_wdata_s;
    logic [NBYTES-1:0]   sel_wstrb_s;

    iob_cache_be_rr_arb u_rr_arb (
        .req   ({m1.avalid, m0.avalid}),
        .last  (last_r),
        .grant (arb_grant_s),
        .valid (arb_valid_s)
    );

    assign sel_avalid_s = (grant_r == MST_1) ? m1.avalid : m0.avalid;
    assign sel_addr_s   = (grant_r == MST_1) ? m1.addr   : m0.addr;
    assign sel_wdata_s  = (grant_r == MST_1) ? m1.wdata  : m0.wdata;
    assign sel_wstrb_s  = (grant_r == MST_1) ? m1.wstrb  : m0.wstrb;

    // State, grant and last-served registers; reset makes m0 win the first tie.
    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            state_r <= ST_IDLE;
            grant_r <= MST_0;
            last_r  <= MST_1;
        end else if (cke_i) begin
            state_r <= state_s;
            grant_r <= grant_s;
            last_r  <= last_s;
        end
    end

    // Next-state logic; the round-robin pointer moves only on acceptance.
    always_comb begin
        state_s = state_r;
        grant_s = grant_r;
        last_s  = last_r;
        case (state_r)
            ST_IDLE: begin
                if (arb_valid_s) begin
                    state_s = ST_REQ;
                    grant_s = arb_grant_s;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                // A request withdrawn before ready is abandoned without access.
                if (!sel_avalid_s) begin
                    state_s = ST_IDLE;
                end else if (mem.ready) begin
                    last_s  = grant_r;
                    state_s = (sel_wstrb_s == {NBYTES{1'b0}}) ? ST_RESP : ST_IDLE;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_RESP: begin
                if (mem.rvalid) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output routing: request pass-through in REQ, response steering in RESP.
    always_comb begin
        mem.avalid = 1'b0;
        mem.addr   = {ADDR_W{1'b0}};
        mem.wdata  = {DATA_W{1'b0}};
        mem.wstrb  = {NBYTES{1'b0}};
        m0.ready   = 1'b0;
        m1.ready   = 1'b0;
        m0.rvalid  = 1'b0;
        m1.rvalid  = 1'b0;
        m0.rdata   = {DATA_W{1'b0}};
        m1.rdata   = {DATA_W{1'b0}};
        case (state_r)
            ST_REQ: begin
                mem.avalid = sel_avalid_s;
                mem.addr   = sel_addr_s;
                mem.wdata  = sel_wdata_s;
                mem.wstrb  = sel_wstrb_s;
                if (grant_r == MST_1) begin
                    m1.ready = mem.ready;
                end else begin
                    m0.ready = mem.ready;
                end
            end
            ST_RESP: begin
                if (grant_r == MST_1) begin
                    m1.rvalid = mem.rvalid;
                    m1.rdata  = mem.rdata;
                end else begin
                    m0.rvalid = mem.rvalid;
                    m0.rdata  = mem.rdata;
                end
            end
            default: begin
                mem.avalid = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_iob_cache_be_arbiter.sv
// Self-checking bench for iob_cache_be_arbiter: queue-driven masters, a
// behavioural memory, and a fairness/routing reference model.
module tb_iob_cache_be_arbiter;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } txn_t;

    logic clk    = 1'b0;
    logic cke_i  = 1'b1;
    logic arst_i = 1'b1;
    always #5 clk = ~clk;

    iob_cache_be_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0_if ();
    iob_cache_be_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1_if ();
    iob_cache_be_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mem_if ();

    iob_cache_be_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i  (clk),
        .cke_i  (cke_i),
        .arst_i (arst_i),
        .m0     (m0_if),
        .m1     (m1_if),
        .mem    (mem_if)
    );

    int checks = 0;
    int errors = 0;

    txn_t        mq [2][$];
    bit          wt [2];
    logic [31:0] exp_d [2];
    logic [31:0] ref_mem [logic [31:0]];
    int          grant_log [$];
    txn_t        acc_log [$];
    int          must_next = -1;
    int          rd_cnt = 0;
    int          lat = 1;
    int          stall_left = 0;
    int          stray_n = 0;
    bit          rand_mode = 1'b0;
    bit          chk_en = 1'b0;
    logic [31:0] rd_data = 32'h0;

    logic        s_avalid [2];
    logic        s_ready  [2];
    logic        s_rvalid [2];
    logic [31:0] s_rdata  [2];
    logic [31:0] s_addr   [2];
    logic [31:0] s_wdata  [2];
    logic [3:0]  s_wstrb  [2];
    logic        s_mavalid, s_mready;
    logic [31:0] s_maddr, s_mwdata;
    logic [3:0]  s_mwstrb;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] st);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic drive_inputs();
        txn_t h0, h1;
        bit   p0, p1;
        p0 = (mq[0].size() > 0) && !wt[0];
        p1 = (mq[1].size() > 0) && !wt[1];
        h0 = p0 ? mq[0][0] : '0;
        h1 = p1 ? mq[1][0] : '0;
        m0_if.avalid = p0; m0_if.addr = h0.addr; m0_if.wdata = h0.wdata; m0_if.wstrb = h0.wstrb;
        m1_if.avalid = p1; m1_if.addr = h1.addr; m1_if.wdata = h1.wdata; m1_if.wstrb = h1.wstrb;
        mem_if.ready = (stall_left == 0);
        if (rd_cnt > 0) begin
            rd_cnt--;
            if (rd_cnt == 0) begin
                mem_if.rvalid = 1'b1;
                mem_if.rdata  = rd_data;
            end else begin
                mem_if.rvalid = 1'b0;
                mem_if.rdata  = $urandom;
            end
        end else if (stray_n > 0) begin
            stray_n--;
            mem_if.rvalid = 1'b1;
            mem_if.rdata  = $urandom;
        end else begin
            mem_if.rvalid = 1'b0;
            mem_if.rdata  = $urandom;
        end
    endtask

    // One clock: sample at negedge, update models and check, drive after posedge.
    task automatic step();
        int   acc_m;
        txn_t t;
        @(negedge clk);
        s_avalid[0] = m0_if.avalid; s_ready[0] = m0_if.ready; s_rvalid[0] = m0_if.rvalid;
        s_rdata[0]  = m0_if.rdata;  s_addr[0]  = m0_if.addr;  s_wdata[0]  = m0_if.wdata;
        s_wstrb[0]  = m0_if.wstrb;
        s_avalid[1] = m1_if.avalid; s_ready[1] = m1_if.ready; s_rvalid[1] = m1_if.rvalid;
        s_rdata[1]  = m1_if.rdata;  s_addr[1]  = m1_if.addr;  s_wdata[1]  = m1_if.wdata;
        s_wstrb[1]  = m1_if.wstrb;
        s_mavalid = mem_if.avalid; s_mready = mem_if.ready; s_maddr = mem_if.addr;
        s_mwdata  = mem_if.wdata;  s_mwstrb = mem_if.wstrb;
        if (chk_en) begin
            for (int m = 0; m < 2; m++) begin
                if (s_rvalid[m]) begin
                    checks++;
                    if (!wt[m] || s_rdata[m] !== exp_d[m]) begin
                        errors++;
                        $display("FAIL rdata_route m%0d: got rvalid=1 rdata=%h, expected outstanding=%0d rdata=%h",
                                 m, s_rdata[m], wt[m], exp_d[m]);
                    end
                    wt[m] = 1'b0;
                end else if (!wt[m]) begin
                    checks++;
                    if (s_rdata[m] !== 32'h0) begin
                        errors++;
                        $display("FAIL idle_rdata m%0d: got %h expected 00000000", m, s_rdata[m]);
                    end
                end
            end
            if (!s_mavalid) begin
                checks++;
                if (s_maddr !== 32'h0 || s_mwdata !== 32'h0 || s_mwstrb !== 4'h0) begin
                    errors++;
                    $display("FAIL mem_idle_fields: got addr=%h wdata=%h wstrb=%h expected all 0",
                             s_maddr, s_mwdata, s_mwstrb);
                end
            end
            if (s_mavalid && stall_left > 0) stall_left--;
            acc_m = -1;
            for (int m = 0; m < 2; m++) begin
                if (s_ready[m]) begin
                    checks++;
                    if (!s_avalid[m] || mq[m].size() == 0 || !s_mavalid || !s_mready ||
                        s_maddr !== s_addr[m] || s_mwdata !== s_wdata[m] ||
                        s_mwstrb !== s_wstrb[m] || acc_m != -1) begin
                        errors++;
                        $display("FAIL accept m%0d: got mem avalid=%b ready=%b addr=%h wstrb=%h, expected pass-through of addr=%h wstrb=%h",
                                 m, s_mavalid, s_mready, s_maddr, s_mwstrb, s_addr[m], s_wstrb[m]);
                    end
                    acc_m = m;
                end
            end
            if (s_mavalid && s_mready) begin
                checks++;
                if (acc_m == -1) begin
                    errors++;
                    $display("FAIL mem_accept_owner: got no master ready, expected exactly one");
                end
            end
            if (acc_m != -1 && mq[acc_m].size() > 0) begin
                if (must_next != -1) begin
                    checks++;
                    if (acc_m != must_next) begin
                        errors++;
                        $display("FAIL fairness: got grant m%0d expected m%0d", acc_m, must_next);
                    end
                end
                must_next = s_avalid[1-acc_m] ? 1 - acc_m : -1;
                grant_log.push_back(acc_m);
                t = mq[acc_m].pop_front();
                acc_log.push_back('{s_maddr, s_mwdata, s_mwstrb});
                if (t.wstrb == 4'h0) begin
                    wt[acc_m]    = 1'b1;
                    exp_d[acc_m] = mem_rd(t.addr);
                    rd_data      = exp_d[acc_m];
                    rd_cnt       = lat;
                end else begin
                    ref_mem[t.addr] = merge(mem_rd(t.addr), t.wdata, t.wstrb);
                end
                if (rand_mode) begin
                    stall_left = $urandom_range(0, 2);
                    lat        = $urandom_range(1, 3);
                end
            end
        end
        @(posedge clk);
        #1;
        drive_inputs();
    endtask

    task automatic clear_model();
        mq[0].delete(); mq[1].delete();
        wt[0] = 1'b0; wt[1] = 1'b0;
        rd_cnt = 0; stall_left = 0; stray_n = 0; must_next = -1;
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        clear_model();
        arst_i = 1'b1;
        step();
        step();
        arst_i = 1'b0;
        chk_en = 1'b1;
    endtask

    task automatic run_until_idle(input int max_cycles, input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (mq[0].size() == 0 && mq[1].size() == 0 && !wt[0] && !wt[1] && rd_cnt == 0) begin
                done = 1'b1;
                break;
            end
            step();
        end
        step();
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_timeout: got pending q0=%0d q1=%0d, expected drained within %0d cycles",
                     name, mq[0].size(), mq[1].size(), max_cycles);
        end
    endtask

    task automatic test_reset();
        do_reset();
        step();
        checks++;
        if (s_mavalid !== 1'b0 || s_maddr !== 32'h0 || s_mwdata !== 32'h0 || s_mwstrb !== 4'h0) begin
            errors++;
            $display("FAIL reset_mem: got avalid=%b addr=%h wdata=%h wstrb=%h expected all 0",
                     s_mavalid, s_maddr, s_mwdata, s_mwstrb);
        end
        checks++;
        if (s_ready[0] !== 1'b0 || s_ready[1] !== 1'b0 || s_rvalid[0] !== 1'b0 || s_rvalid[1] !== 1'b0) begin
            errors++;
            $display("FAIL reset_master: got ready=%b%b rvalid=%b%b expected 0", s_ready[1], s_ready[0],
                     s_rvalid[1], s_rvalid[0]);
        end
    endtask

    task automatic test_single_read();
        lat = 2;
        ref_mem[32'h100] = 32'hDEAD_BEEF;
        mq[0].push_back('{32'h100, 32'h0, 4'h0});
        step();
        for (int c = 0; c < 6; c++) begin
            step();
            checks++;
            if (s_rvalid[1] !== 1'b0) begin
                errors++;
                $display("FAIL single_read_m1_rvalid c%0d: got %b expected 0", c, s_rvalid[1]);
            end
            if (c == 0 || c == 1) begin
                checks++;
                if (s_ready[0] !== (c == 1)) begin
                    errors++;
                    $display("FAIL single_read_ready c%0d: got %b expected %0d", c, s_ready[0], c == 1);
                end
            end
            if (c == 2 || c == 3) begin
                checks++;
                if (s_rvalid[0] !== (c == 3) || (c == 3 && s_rdata[0] !== 32'hDEAD_BEEF)) begin
                    errors++;
                    $display("FAIL single_read_data c%0d: got rvalid=%b rdata=%h expected rvalid=%0d rdata=deadbeef",
                             c, s_rvalid[0], s_rdata[0], c == 3);
                end
            end
        end
        lat = 1;
    endtask

    task automatic test_simultaneous();
        do_reset();
        grant_log.delete(); acc_log.delete();
        mq[0].push_back('{32'h10, 32'h1111_1111, 4'hF});
        mq[1].push_back('{32'h20, 32'h2222_2222, 4'hF});
        run_until_idle(50, "simultaneous");
        checks++;
        if (grant_log.size() != 2 || acc_log.size() != 2 ||
            acc_log[0] !== txn_t'{32'h10, 32'h1111_1111, 4'hF} ||
            acc_log[1] !== txn_t'{32'h20, 32'h2222_2222, 4'hF}) begin
            errors++;
            $display("FAIL simultaneous_order: got %0d accesses first=%h, expected m0 write 0x10 then m1 write 0x20",
                     acc_log.size(), (acc_log.size() > 0) ? acc_log[0].addr : 32'hFFFF_FFFF);
        end
    endtask

    task automatic test_fairness();
        grant_log.delete();
        rand_mode = 1'b1;
        for (int i = 0; i < 8; i++) begin
            for (int m = 0; m < 2; m++) begin
                logic [31:0] a;
                a = 32'h1000 + 32'h100 * m + 4 * i;
                ref_mem[a] = $urandom;
                mq[m].push_back('{a, 32'h0, 4'h0});
            end
        end
        run_until_idle(400, "fairness");
        rand_mode = 1'b0; lat = 1; stall_left = 0;
        checks++;
        if (grant_log.size() != 16) begin
            errors++;
            $display("FAIL fairness_count: got %0d grants expected 16", grant_log.size());
        end
        for (int i = 0; i < grant_log.size(); i++) begin
            checks++;
            if (grant_log[i] != i % 2) begin
                errors++;
                $display("FAIL fairness_seq[%0d]: got m%0d expected m%0d", i, grant_log[i], i % 2);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        grant_log.delete(); acc_log.delete();
        mq[0].push_back('{32'h200, 32'hA0A0_A0A0, 4'hF});
        mq[1].push_back('{32'h300, 32'hB0B0_B0B0, 4'h3});
        stall_left = 5;
        step();
        for (int c = 0; c < 7; c++) begin
            step();
            if (c >= 1 && c <= 5) begin
                checks++;
                if (s_mavalid !== 1'b1 || s_maddr !== 32'h200 || s_ready[0] !== 1'b0 || s_ready[1] !== 1'b0) begin
                    errors++;
                    $display("FAIL backpressure_hold c%0d: got avalid=%b addr=%h ready=%b%b expected 1/00000200/00",
                             c, s_mavalid, s_maddr, s_ready[1], s_ready[0]);
                end
            end
            if (c == 6) begin
                checks++;
                if (s_ready[0] !== 1'b1 || s_ready[1] !== 1'b0) begin
                    errors++;
                    $display("FAIL backpressure_accept: got ready=%b%b expected 01", s_ready[1], s_ready[0]);
                end
            end
        end
        run_until_idle(50, "backpressure");
        checks++;
        if (grant_log.size() != 2 || grant_log[0] != 0 || grant_log[1] != 1 || acc_log[1].addr !== 32'h300) begin
            errors++;
            $display("FAIL backpressure_order: got %0d grants, expected m0 then m1", grant_log.size());
        end
    endtask

    task automatic test_stray();
        stray_n = 3;
        step();
        for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if (s_rvalid[0] !== 1'b0 || s_rvalid[1] !== 1'b0) begin
                errors++;
                $display("FAIL stray_rvalid c%0d: got %b%b expected 00", c, s_rvalid[1], s_rvalid[0]);
            end
        end
        mq[0].push_back('{32'h400, 32'h1234_5678, 4'hF});
        step();
        step();
        step();
        checks++;
        if (s_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL stray_idle: got m0_ready=%b one cycle after avalid, expected 1", s_ready[0]);
        end
        run_until_idle(20, "stray");
    endtask

    task automatic test_reset_in_resp();
        int n;
        lat = 10;
        n = grant_log.size();
        mq[0].push_back('{32'h500, 32'h0, 4'h0});
        for (int i = 0; i < 10 && grant_log.size() == n; i++) step();
        step();
        arst_i = 1'b1;
        step();
        arst_i = 1'b0;
        wt[0] = 1'b0; must_next = -1;
        step();
        checks++;
        if (s_mavalid !== 1'b0 || s_maddr !== 32'h0 || s_ready[0] !== 1'b0 || s_ready[1] !== 1'b0 ||
            s_rvalid[0] !== 1'b0 || s_rdata[0] !== 32'h0 || s_rdata[1] !== 32'h0) begin
            errors++;
            $display("FAIL reset_resp_outputs: got avalid=%b ready=%b%b rvalid0=%b rdata0=%h expected all 0",
                     s_mavalid, s_ready[1], s_ready[0], s_rvalid[0], s_rdata[0]);
        end
        for (int i = 0; i < 20 && rd_cnt > 0; i++) step();
        step();
        checks++;
        if (s_rvalid[0] !== 1'b0 || s_rvalid[1] !== 1'b0) begin
            errors++;
            $display("FAIL reset_resp_late: got rvalid=%b%b expected 00", s_rvalid[1], s_rvalid[0]);
        end
        lat = 1;
        grant_log.delete();
        mq[0].push_back('{32'h600, 32'h6666_6666, 4'hF});
        mq[1].push_back('{32'h700, 32'h7777_7777, 4'hF});
        run_until_idle(50, "reset_resp");
        checks++;
        if (grant_log.size() != 2 || grant_log[0] != 0) begin
            errors++;
            $display("FAIL reset_resp_tie: got first grant m%0d expected m0",
                     (grant_log.size() > 0) ? grant_log[0] : -1);
        end
    endtask

    task automatic test_random();
        grant_log.delete();
        rand_mode = 1'b1;
        for (int i = 0; i < 30; i++) begin
            for (int m = 0; m < 2; m++) begin
                logic [3:0] st;
                st = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                mq[m].push_back('{32'h40 + 32'(4 * $urandom_range(0, 7)), 32'($urandom), st});
            end
        end
        run_until_idle(3000, "random");
        rand_mode = 1'b0; lat = 1; stall_left = 0;
        checks++;
        if (grant_log.size() != 60) begin
            errors++;
            $display("FAIL random_count: got %0d grants expected 60", grant_log.size());
        end
    endtask

    initial begin
        m0_if.avalid = 1'b0; m0_if.addr = 32'h0; m0_if.wdata = 32'h0; m0_if.wstrb = 4'h0;
        m1_if.avalid = 1'b0; m1_if.addr = 32'h0; m1_if.wdata = 32'h0; m1_if.wstrb = 4'h0;
        mem_if.ready = 1'b1; mem_if.rvalid = 1'b0; mem_if.rdata = 32'h0;
        test_reset();
        test_single_read();
        test_simultaneous();
        test_fairness();
        test_backpressure();
        test_stray();
        test_reset_in_resp();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
